fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_if.sv | 49 ++++
 rtl/fpu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_fpu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_if.sv
// Request/unit/result bundle between the FP pipeline front end and fpu_issue_ctrl.
// slave = the controller, master = whoever drives requests and models the units.
interface fpu_issue_if #(
  parameter int W  = 32,
  parameter int NU = 8
);
  localparam int UW = $clog2(NU);

  logic            op_valid;
  logic            op_multi;
  logic [UW-1:0]   op_unit;
  logic            op_neg_b;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    op_c;
  logic            op_ready;
  logic            stall;

  logic [NU-1:0]   unit_start;
  logic [W-1:0]    unit_a;
  logic [W-1:0]    unit_b;
  logic [W-1:0]    unit_c;
  logic [NU-1:0]   unit_done;
  logic [NU*W-1:0] unit_res;
  logic [W-1:0]    comb_res;

  logic            res_valid;
  logic [W-1:0]    res;
  logic            err_timeout;
  logic            err_illegal;
  logic [1:0]      dbg_state;

  // Handshake: a request transfers on a clock edge where op_valid && op_ready;
  // op_ready is high only while the controller is idle, and the requester
  // must hold its fields stable while stall is high.
  modport slave (
    input  op_valid, op_multi, op_unit, op_neg_b, op_a, op_b, op_c,
    input  unit_done, unit_res, comb_res,
    output op_ready, stall, unit_start, unit_a, unit_b, unit_c,
    output res_valid, res, err_timeout, err_illegal, dbg_state
  );

  modport master (
    output op_valid, op_multi, op_unit, op_neg_b, op_a, op_b, op_c,
    output unit_done, unit_res, comb_res,
    input  op_ready, stall, unit_start, unit_a, unit_b, unit_c,
    input  res_valid, res, err_timeout, err_illegal, dbg_state
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for one combinational FP path and NU multi-cycle FP units,
// with at most one unit outstanding and a NaN-substituting timeout.
module fpu_issue_ctrl #(
  parameter int             W       = 32,
  parameter int             NU      = 8,
  parameter int             TIMEOUT = 64,
  parameter logic [W-1:0]   NAN_VAL = W'(32'h7FC00000)
) (
  input logic        g_clk,
  input logic        g_rst,
  fpu_issue_if.slave bus
);
  localparam int UW = $clog2(NU);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [UW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [NU-1:0] start_q;
  logic [W-1:0]  ua_q, ub_q, uc_q;
  logic          res_valid_q;
  logic [W-1:0]  res_q;
  logic          err_to_q;
  logic          err_ill_q;

  logic          accept;
  logic          unit_legal;
  logic          done_sel;
  logic [W-1:0]  res_sel;

  assign accept     = bus.op_valid && (state == S_IDLE);
  // Only reachable as false when NU is not a power of two.
  assign unit_legal = int'(bus.op_unit) < NU;
  assign done_sel   = bus.unit_done[idx];
  assign res_sel    = bus.unit_res[int'(idx)*W +: W];

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      start_q     <= '0;
      ua_q        <= '0;
      ub_q        <= '0;
      uc_q        <= '0;
      res_valid_q <= 1'b0;
      res_q       <= NAN_VAL;
      err_to_q    <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      start_q     <= '0;
      res_valid_q <= 1'b0;
      err_ill_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!bus.op_multi) begin
              res_q       <= bus.comb_res;
              res_valid_q <= 1'b1;
            end else if (unit_legal) begin
              ua_q    <= bus.op_a;
              ub_q    <= {bus.op_b[W-1] ^ bus.op_neg_b, bus.op_b[W-2:0]};
              uc_q    <= bus.op_c;
              idx     <= bus.op_unit;
              start_q <= NU'(1) << bus.op_unit;
              state   <= S_ISSUE;
            end else begin
              res_q       <= NAN_VAL;
              res_valid_q <= 1'b1;
              err_ill_q   <= 1'b1;
            end
          end
        end
        // start_q is high for exactly this cycle; done is not looked at yet.
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sel) begin
            res_q       <= res_sel;
            res_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            res_q       <= NAN_VAL;
            res_valid_q <= 1'b1;
            err_to_q    <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready    = (state == S_IDLE);
  assign bus.stall       = bus.op_valid && (state != S_IDLE);
  assign bus.unit_start  = start_q;
  assign bus.unit_a      = ua_q;
  assign bus.unit_b      = ub_q;
  assign bus.unit_c      = uc_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res         = res_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_illegal = err_ill_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with NU=6 and TIMEOUT=8: a vector table for
// single operations plus hand sequences for timeout, done-at-limit and reset.
module tb_fpu_issue_ctrl;
  localparam int          W   = 32;
  localparam int          NU  = 6;
  localparam int          TO  = 8;
  localparam logic [31:0] NAN = 32'h7FC00000;

  typedef struct {
    logic        multi;
    logic [2:0]  unit;
    logic        neg_b;
    logic [31:0] a, b, c;
    logic [31:0] rval;
    logic [31:0] exp_b;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  logic g_clk = 1'b0;
  logic g_rst;
  always #5 g_clk = ~g_clk;

  fpu_issue_if #(.W(W), .NU(NU)) bus ();

  fpu_issue_ctrl #(.W(W), .NU(NU), .TIMEOUT(TO), .NAN_VAL(NAN)) dut (
    .g_clk (g_clk),
    .g_rst (g_rst),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic multi, input logic [2:0] unit, input logic neg_b,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] rval, input logic [31:0] exp_b,
                              input logic [31:0] exp_res, input logic exp_ill);
    vec_t v;
    v.multi = multi; v.unit = unit; v.neg_b = neg_b;
    v.a = a; v.b = b; v.c = c; v.rval = rval;
    v.exp_b = exp_b; v.exp_res = exp_res; v.exp_ill = exp_ill;
    return v;
  endfunction

  // Scoreboard: every res_valid must match the oldest expected result.
  always @(negedge g_clk) begin
    if (!g_rst && bus.res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 32'(bus.res_valid), 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_res", bus.res, sb_exp);
      end
    end
  end

  task automatic idle_inputs();
    bus.op_valid  = 1'b0;
    bus.op_multi  = 1'b0;
    bus.op_unit   = '0;
    bus.op_neg_b  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_c      = '0;
    bus.unit_done = '0;
    bus.comb_res  = 32'h0BAD_0BAD;
    for (int i = 0; i < NU; i++) bus.unit_res[i*W +: W] = 32'hA000_0000 | 32'(i);
  endtask

  task automatic drive_req(input logic multi, input logic [2:0] unit, input logic neg_b,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.op_valid = 1'b1;
    bus.op_multi = multi;
    bus.op_unit  = unit;
    bus.op_neg_b = neg_b;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_c     = c;
  endtask

  // One table operation; multi-cycle units answer three cycles after start.
  task automatic run_vec(input vec_t v);
    @(negedge g_clk);
    check("ready_before_op", 32'(bus.op_ready), 32'd1);
    drive_req(v.multi, v.unit, v.neg_b, v.a, v.b, v.c);
    bus.comb_res = v.multi ? 32'h1111_1111 : v.rval;
    if (!v.multi || v.exp_ill) begin
      exp_q.push_back(v.exp_res);
      @(negedge g_clk);
      bus.op_valid = 1'b0;
      check("short_res_valid", 32'(bus.res_valid), 32'd1);
      check("short_err_illegal", 32'(bus.err_illegal), 32'(v.exp_ill));
      check("short_no_start", 32'(bus.unit_start), 32'd0);
      @(negedge g_clk);
      check("err_illegal_pulse", 32'(bus.err_illegal), 32'd0);
    end else begin
      @(negedge g_clk);
      check("issue_start", 32'(bus.unit_start), 32'(6'b1 << v.unit));
      check("issue_unit_a", bus.unit_a, v.a);
      check("issue_unit_b", bus.unit_b, v.exp_b);
      check("issue_unit_c", bus.unit_c, v.c);
      check("issue_stall", 32'(bus.stall), 32'd1);
      check("issue_state", 32'(bus.dbg_state), 32'd1);
      bus.op_a = ~v.a;
      bus.unit_done = '1;
      bus.unit_res[int'(v.unit)*W +: W] = 32'hBAD0_BAD0;
      @(negedge g_clk);
      check("wait_no_res", 32'(bus.res_valid), 32'd0);
      check("wait_start_low", 32'(bus.unit_start), 32'd0);
      check("wait_state", 32'(bus.dbg_state), 32'd2);
      bus.unit_done = ~(6'b1 << v.unit);
      @(negedge g_clk);
      check("other_done_ignored", 32'(bus.res_valid), 32'd0);
      check("unit_a_held", bus.unit_a, v.a);
      bus.unit_done = '0;
      @(negedge g_clk);
      bus.unit_done = 6'b1 << v.unit;
      bus.unit_res[int'(v.unit)*W +: W] = v.rval;
      exp_q.push_back(v.exp_res);
      @(negedge g_clk);
      check("multi_res_valid", 32'(bus.res_valid), 32'd1);
      check("multi_ready_after", 32'(bus.op_ready), 32'd1);
      idle_inputs();
      check("stall_released", 32'(bus.stall), 32'd0);
    end
  endtask

  // Accept on unit, then WAIT cycles 2..9; done_cyc=0 means the unit never answers.
  task automatic run_long(input logic [2:0] unit, input int done_cyc, input logic [31:0] rval,
                          input logic [31:0] exp_res, input logic exp_to);
    @(negedge g_clk);
    drive_req(1'b1, unit, 1'b0, 32'h1, 32'h2, 32'h3);
    exp_q.push_back(exp_res);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge g_clk);
      bus.op_valid = 1'b0;
      if (cyc == done_cyc) begin
        bus.unit_done = 6'b1 << unit;
        bus.unit_res[int'(unit)*W +: W] = rval;
      end
    end
    check("long_no_early_res", 32'(bus.res_valid), 32'd0);
    check("long_no_early_to", 32'(bus.err_timeout), 32'd0);
    @(negedge g_clk);
    check("long_res_valid", 32'(bus.res_valid), 32'd1);
    check("long_err_timeout", 32'(bus.err_timeout), 32'(exp_to));
    check("long_ready_after", 32'(bus.op_ready), 32'd1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0);
    vecs[1] = mk(1'b1, 3'd0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4040_0000,
                 32'h4000_0000, 32'h4040_0000, 1'b0);
    vecs[2] = mk(1'b1, 3'd3, 1'b1, 32'h1, 32'h4000_0000, 32'h7, 32'h3F00_0000,
                 32'hC000_0000, 32'h3F00_0000, 1'b0);
    vecs[3] = mk(1'b1, 3'd5, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'hCAFE_0000, 32'hDEAD_BEEF,
                 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
    vecs[4] = mk(1'b1, 3'd7, 1'b0, 32'h5, 32'h6, 32'h7, 32'h0, 32'h0, NAN, 1'b1);
    vecs[5] = mk(1'b1, 3'd6, 1'b1, 32'h5, 32'h6, 32'h7, 32'h0, 32'h0, NAN, 1'b1);
    vecs[6] = mk(1'b0, 3'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0);

    idle_inputs();
    g_rst = 1'b1;
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    check("rst_op_ready", 32'(bus.op_ready), 32'd1);
    check("rst_res", bus.res, NAN);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_unit_a", bus.unit_a, 32'd0);
    check("rst_unit_start", 32'(bus.unit_start), 32'd0);
    check("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Three combinational ops back to back.
    for (int i = 1; i <= 3; i++) begin
      @(negedge g_clk);
      if (i > 1) check("b2b_res_valid", 32'(bus.res_valid), 32'd1);
      drive_req(1'b0, 3'd0, 1'b0, 32'(i), 32'(i), 32'(i));
      bus.comb_res = 32'(i);
      exp_q.push_back(32'(i));
      check("b2b_stall", 32'(bus.stall), 32'd0);
    end
    @(negedge g_clk);
    bus.op_valid = 1'b0;
    check("b2b_res_valid_last", 32'(bus.res_valid), 32'd1);
    @(negedge g_clk);
    check("b2b_quiet", 32'(bus.res_valid), 32'd0);

    run_long(3'd1, 9, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0);
    run_long(3'd2, 0, 32'h0, NAN, 1'b1);
    run_vec(vecs[0]);
    check("timeout_sticky", 32'(bus.err_timeout), 32'd1);

    // Reset in the middle of WAIT, then a late done from the abandoned unit.
    @(negedge g_clk);
    drive_req(1'b1, 3'd4, 1'b0, 32'h9, 32'h9, 32'h9);
    repeat (3) @(negedge g_clk);
    bus.op_valid = 1'b0;
    check("pre_rst_state", 32'(bus.dbg_state), 32'd2);
    g_rst = 1'b1;
    @(negedge g_clk);
    g_rst = 1'b0;
    bus.unit_done = 6'b1 << 4;
    bus.unit_res[4*W +: W] = 32'h1357_9BDF;
    @(negedge g_clk);
    check("late_done_no_res", 32'(bus.res_valid), 32'd0);
    check("late_done_res", bus.res, NAN);
    check("late_done_state", 32'(bus.dbg_state), 32'd0);
    check("rst_clears_timeout", 32'(bus.err_timeout), 32'd0);
    check("rst_clears_unit_a", bus.unit_a, 32'd0);
    idle_inputs();
    repeat (3) @(negedge g_clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
